udp_chan_arbiter: RTL and testbench
===================================

// Module: udp_chan_arbiter
// PURPOSE
//  Round-robin scheduler sharing one UDP transmit engine among NCH ping-pong pre-buffer channels.
//  Each channel fills one RAM bank per frame, then pulses a start request.
//  This block latches each request and the filled bank, and grants the engine to one channel at a time.
//  It drives the engine's start, channel select and bank select, and returns a per-channel busy so each
//  producer holds off its next frame. Sits between the channel buffers and the UDP packet sender.
// PARAMETERS
//  NCH      4      number of requesting channels (2..8)
//  CW       2      channel index width, >= clog2(NCH)
//  TIMEOUT  50000  cycles to wait for tx_busy to rise after tx_start (used only with UDP_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1      system clock
//  nRST         in   1      asynchronous reset, active-low
//  req          in   NCH    per-channel start request (level, >=1 cycle; rising edge = new frame)
//  req_bank     in   NCH    per-channel bank holding the completed frame, sampled on req rising edge
//  tx_busy      in   1      UDP engine busy, high while a frame is being sent
//  tx_start     out  1      one-cycle start pulse to the UDP engine
//  tx_ch        out  CW     granted channel index, stable from tx_start until release
//  tx_bank      out  1      granted bank (RAM address MSB), stable as tx_ch
//  ch_busy      out  NCH    per-channel busy returned to the producers
//  overflow     out  NCH    sticky: new request while the same channel was still pending or granted
//  timeout_err  out  1      sticky: engine never raised tx_busy (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: tx_start=0, tx_ch=0, tx_bank=0, ch_busy=0, overflow=0, timeout_err=0.
//    Reset also clears pending bits, sets rr pointer=0 and FSM state=IDLE. Reset is legal mid-transfer
//    and abandons the transfer.
//  - req is edge-detected with one register stage; pend[i] and bank[i] are set on the cycle after the edge.
//  - Edge on channel i while pend[i]=1 or i is granted: set overflow[i]; bank[i] := new req_bank; no extra grant.
//  - Exception: an edge arriving in the RELEASE cycle of channel i is a legal new request, not overflow.
//  - ch_busy[i] = pend[i] | (granted==i and state!=IDLE), registered.
//  - FSM states:
//    - IDLE: if any pend, go to ARB.
//    - ARB: pick the first pend[i] at or after rr (wrapping modulo NCH). Load tx_ch/tx_bank, clear pend[i].
//      Go to START.
//    - START: tx_start=1 for exactly 1 cycle. Go to WAIT_HI.
//    - WAIT_HI: wait for tx_busy=1. Go to WAIT_LO.
//    - WAIT_LO: wait for tx_busy=0. Go to RELEASE.
//    - RELEASE: rr := (tx_ch+1) mod NCH (wrap NCH-1 -> 0). Clear the grant. Go to IDLE.
//  - Latency: req edge -> tx_start = 4 cycles when the engine is idle (edge reg, pend, ARB, START).
//  - Simultaneous edges on several channels are all latched the same cycle and served in rr order.
//  - No starvation: each pending channel is served within NCH grants.
//  - tx_busy already high in START is accepted in WAIT_HI on the next cycle.
// CONFIGURATION
//  - UDP_ARB_TIMEOUT_EN defined:
//    - A 16-bit counter runs in WAIT_HI and clears on entry.
//    - On reaching TIMEOUT: set timeout_err, skip to RELEASE and drop the frame.
//  - UDP_ARB_TIMEOUT_EN undefined: WAIT_HI waits forever; timeout_err is tied 0.
// TESTING
//  - Single: req[1] edge, bank=1, engine busy 20 cycles -> tx_start 4 cycles later, tx_ch=1, tx_bank=1,
//    ch_busy[1] high until RELEASE.
//  - Simultaneous: req=4'b1011 same cycle, rr=0 -> grant order 0,1,3; rr=0 after the last grant.
//  - Wrap: rr=3, pend=4'b1001 -> grant ch3 then ch0; rr ends at 1.
//  - Overflow: second req[2] edge while ch2 granted -> overflow[2]=1, exactly one extra grant with the new bank.
//  - Timeout (macro on, TIMEOUT=100): tx_busy held 0 -> timeout_err=1 at 100 cycles, next pending channel granted.
//    Macro off: FSM stays in WAIT_HI.
//  - Reset mid-WAIT_LO: nRST low -> all outputs 0 immediately; after release, the state is IDLE with no stale pend.

Source files
------------

// File: rtl/udp_chan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : udp_chan_arbiter
//  Purpose  : Round-robin scheduler sharing one UDP transmit engine among NCH
//             ping-pong pre-buffer channels. Latches each channel's start
//             request and filled bank, grants the engine to one channel at a
//             time and returns a per-channel busy to the producers.
//  Options  : UDP_ARB_TIMEOUT_EN - when defined, a grant whose engine never
//             raises tx_busy is abandoned after TIMEOUT cycles and flagged on
//             timeout_err; when undefined the arbiter waits indefinitely.
//  Revision : 1.0 - initial release
// ============================================================================
module udp_chan_arbiter #(
    parameter int NCH     = 4,
    parameter int CW      = 2,
    parameter int TIMEOUT = 50000
) (
    input  logic           clk,
    input  logic           nRST,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] req_bank,
    input  logic           tx_busy,
    output logic           tx_start,
    output logic [CW-1:0]  tx_ch,
    output logic           tx_bank,
    output logic [NCH-1:0] ch_busy,
    output logic [NCH-1:0] overflow,
    output logic           timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_START   = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    localparam logic [CW-1:0] c_last_ch = CW'(NCH - 1);

    state_t         r_state;
    logic [NCH-1:0] r_req_d;      // previous req level for edge detection
    logic [NCH-1:0] r_edge;       // registered rising edges of req
    logic [NCH-1:0] r_edge_bank;  // req_bank captured alongside r_edge
    logic [NCH-1:0] r_pend;       // frame waiting for the engine
    logic [NCH-1:0] r_bank;       // bank of the waiting frame
    logic           r_act;        // a grant is held (ARB load until RELEASE)
    logic [CW-1:0]  r_rr;         // round-robin search start
    logic [NCH-1:0] w_granted;    // one-hot view of the current grant
    logic [CW-1:0]  w_pick;       // first pending channel at or after r_rr

    // Reject parameter sets the datapath cannot represent
    if ((NCH < 2) || (NCH > 8) || (CW < $clog2(NCH)) || (TIMEOUT < 1) || (TIMEOUT > 65536)) begin : g_param_check
        $error("udp_chan_arbiter: unsupported parameter combination");
    end

    // One-hot grant vector used by overflow detection and ch_busy
    for (genvar gi = 0; gi < NCH; gi++) begin : g_grant
        assign w_granted[gi] = r_act && (tx_ch == CW'(gi));
    end

    // Round-robin pick: scan downward so the smallest offset from r_rr wins
    always_comb begin
        w_pick = r_rr;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (r_pend[(int'(r_rr) + k) % NCH]) begin
                w_pick = CW'((int'(r_rr) + k) % NCH);
            end
        end
    end

    // Single register stage detecting new-frame edges and their bank
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_req_d     <= '0;
            r_edge      <= '0;
            r_edge_bank <= '0;
        end else begin
            r_req_d     <= req;
            r_edge      <= req & ~r_req_d;
            r_edge_bank <= req_bank;
        end
    end

`ifdef UDP_ARB_TIMEOUT_EN
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);
    logic [15:0] r_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Grant controller: request latching, arbitration and engine handshake
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state  <= S_IDLE;
            r_pend   <= '0;
            r_bank   <= '0;
            r_rr     <= '0;
            r_act    <= 1'b0;
            tx_start <= 1'b0;
            tx_ch    <= '0;
            tx_bank  <= 1'b0;
            overflow <= '0;
`ifdef UDP_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|r_pend) begin
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    tx_ch          <= w_pick;
                    tx_bank        <= r_bank[w_pick];
                    r_pend[w_pick] <= 1'b0;
                    r_act          <= 1'b1;
                    tx_start       <= 1'b1;
                    r_state        <= S_START;
                end
                S_START: begin
                    r_state <= S_WAIT_HI;
`ifdef UDP_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        r_state <= S_WAIT_LO;
                    end
`ifdef UDP_ARB_TIMEOUT_EN
                    else if (r_cnt == c_timeout_last) begin
                        // Engine never answered: drop the frame, move on
                        timeout_err <= 1'b1;
                        r_state     <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
`endif
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_rr    <= (tx_ch == c_last_ch) ? '0 : tx_ch + CW'(1);
                    r_act   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // New frames always queue and refresh the bank; placed after the
            // case so a same-cycle ARB clear cannot swallow a fresh request.
            // A channel being released may legally request again.
            for (int i = 0; i < NCH; i++) begin
                if (r_edge[i]) begin
                    if (r_pend[i] || (w_granted[i] && (r_state != S_RELEASE))) begin
                        overflow[i] <= 1'b1;
                    end
                    r_pend[i] <= 1'b1;
                    r_bank[i] <= r_edge_bank[i];
                end
            end
        end
    end

    // Registered per-channel busy returned to the producers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ch_busy <= '0;
        end else begin
            ch_busy <= r_pend | w_granted;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_chan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udp_chan_arbiter
//  Purpose  : Self-checking bench for udp_chan_arbiter; a transaction-level
//             round-robin model predicts grant order, banks and overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_udp_chan_arbiter;
    localparam int NCH = 4;
    localparam int CW  = 2;
`ifdef UDP_ARB_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 50000;
`endif

    logic           clk      = 1'b0;
    logic           nRST     = 1'b0;
    logic [NCH-1:0] req      = '0;
    logic [NCH-1:0] req_bank = '0;
    logic           tx_busy  = 1'b0;
    logic           tx_start;
    logic [CW-1:0]  tx_ch;
    logic           tx_bank;
    logic [NCH-1:0] ch_busy;
    logic [NCH-1:0] overflow;
    logic           timeout_err;

    int n_pass   = 0;
    int n_chk    = 0;
    int n_starts = 0;

    // Reference model state
    bit             m_pend [NCH];
    bit             m_bank [NCH];
    logic [NCH-1:0] m_ovf;
    int             m_rr;
    int             got_ch[$];
    bit             got_bank[$];

    udp_chan_arbiter #(.NCH(NCH), .CW(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .nRST(nRST), .req(req), .req_bank(req_bank), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_ch(tx_ch), .tx_bank(tx_bank), .ch_busy(ch_busy),
        .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_start === 1'b1) n_starts++;

    function automatic bit any_pend();
        bit a = 1'b0;
        for (int i = 0; i < NCH; i++) a |= m_pend[i];
        return a;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        nRST = 1'b0; req = '0; req_bank = '0; tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        for (int i = 0; i < NCH; i++) begin m_pend[i] = 1'b0; m_bank[i] = 1'b0; end
        m_ovf = '0;
        m_rr  = 0;
    endtask

    // Engine model: waits for a start, answers, optionally re-fires the granted
    // channel (mode 1: while busy, mode 2: in the cycle busy drops)
    task automatic serve(input int dly, input int len, input int mode, input bit nb,
                         output int ch, output bit bk);
        int t = 0;
        while (tx_start !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        n_chk++;
        if (tx_start !== 1'b1) begin
            $display("FAIL start_wait: tx_start=%b after %0d cycles, required 1", tx_start, t);
            ch = -1; bk = 1'b0;
            return;
        end
        n_pass++;
        ch = int'(tx_ch); bk = tx_bank;
        got_ch.push_back(ch); got_bank.push_back(bk);
        repeat (dly) @(negedge clk);
        tx_busy = 1'b1;
        if (mode == 1) begin req[ch] = 1'b1; req_bank[ch] = nb; end
        @(negedge clk);
        req = '0;
        repeat (len - 1) @(negedge clk);
        n_chk++;
        if (ch_busy[ch] !== 1'b1) $display("FAIL ch_busy_hold: ch%0d ch_busy=%b, required bit set", ch, ch_busy);
        else n_pass++;
        tx_busy = 1'b0;
        if (mode == 2) begin
            req[ch] = 1'b1; req_bank[ch] = nb;
            @(negedge clk);
            req = '0;
        end
    endtask

    task automatic run_round(input logic [NCH-1:0] mask, input logic [NCH-1:0] banks,
                             input int mode, input bit nb);
        int exp_ch, ch, s0, ngr, mode_now;
        bit bk, exp_bk;
        bit first = 1'b1;
        s0 = n_starts; ngr = 0;
        for (int i = 0; i < NCH; i++) if (mask[i]) begin m_pend[i] = 1'b1; m_bank[i] = banks[i]; end
        @(negedge clk); req = mask; req_bank = banks;
        @(negedge clk); req = '0;
        while (any_pend()) begin
            exp_ch = -1;
            for (int k = 0; k < NCH; k++)
                if (exp_ch < 0 && m_pend[(m_rr + k) % NCH]) exp_ch = (m_rr + k) % NCH;
            exp_bk = m_bank[exp_ch];
            m_pend[exp_ch] = 1'b0;
            mode_now = first ? mode : 0;
            first = 1'b0;
            serve(int'($urandom_range(0, 3)), int'($urandom_range(2, 6)), mode_now, nb, ch, bk);
            ngr++;
            n_chk++;
            if (ch !== exp_ch || bk !== exp_bk)
                $display("FAIL grant: got ch%0d bank%0d, required ch%0d bank%0d", ch, bk, exp_ch, exp_bk);
            else n_pass++;
            if (ch < 0) break;
            if (mode_now != 0) begin
                m_pend[exp_ch] = 1'b1;
                m_bank[exp_ch] = nb;
                if (mode_now == 1) m_ovf[exp_ch] = 1'b1;
            end
            m_rr = (exp_ch + 1) % NCH;
        end
        repeat (8) @(negedge clk);
        n_chk++;
        if (n_starts - s0 !== ngr) $display("FAIL start_count: %0d pulses, required %0d", n_starts - s0, ngr);
        else n_pass++;
        n_chk++;
        if (ch_busy !== '0) $display("FAIL idle_busy: ch_busy=%b, required 0000", ch_busy);
        else n_pass++;
        n_chk++;
        if (overflow !== m_ovf) $display("FAIL overflow: overflow=%b, required %b", overflow, m_ovf);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (tx_start !== 1'b0 || tx_ch !== '0 || tx_bank !== 1'b0)
            $display("FAIL reset_tx: start=%b ch=%0d bank=%b, required 0/0/0", tx_start, tx_ch, tx_bank);
        else n_pass++;
        n_chk++;
        if (ch_busy !== '0 || overflow !== '0 || timeout_err !== 1'b0)
            $display("FAIL reset_flags: busy=%b ovf=%b to=%b, required zeros", ch_busy, overflow, timeout_err);
        else n_pass++;
        nRST = 1'b1;
        for (int i = 0; i < NCH; i++) begin m_pend[i] = 1'b0; m_bank[i] = 1'b0; end
        m_ovf = '0; m_rr = 0;
    endtask

    task automatic test_single();
        int n = 0;
        int s0 = n_starts;
        @(negedge clk); req = 4'b0010; req_bank = 4'b0010;
        do begin @(negedge clk); n++; req = '0; end while (tx_start !== 1'b1 && n < 20);
        n_chk++;
        if (n !== 4) $display("FAIL single_latency: %0d cycles, required 4", n);
        else n_pass++;
        n_chk++;
        if (tx_ch !== 2'd1 || tx_bank !== 1'b1)
            $display("FAIL single_grant: ch=%0d bank=%b, required ch1 bank1", tx_ch, tx_bank);
        else n_pass++;
        tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        n_chk++;
        if (ch_busy !== 4'b0010) $display("FAIL single_busy: ch_busy=%b, required 0010", ch_busy);
        else n_pass++;
        tx_busy = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (ch_busy !== 4'b0000 || n_starts - s0 !== 1)
            $display("FAIL single_release: ch_busy=%b starts=%0d, required 0000 and 1", ch_busy, n_starts - s0);
        else n_pass++;
        m_rr = 2;
    endtask

    task automatic test_simultaneous();
        do_reset();
        got_ch.delete(); got_bank.delete();
        run_round(4'b1011, 4'($urandom), 0, 1'b0);
        n_chk++;
        if (got_ch.size() != 3 || got_ch[0] != 0 || got_ch[1] != 1 || got_ch[2] != 3)
            $display("FAIL simul_order: %p, required '{0,1,3}", got_ch);
        else n_pass++;
    endtask

    task automatic test_wrap();
        run_round(4'b0100, 4'($urandom), 0, 1'b0);
        got_ch.delete(); got_bank.delete();
        run_round(4'b1001, 4'($urandom), 0, 1'b0);
        n_chk++;
        if (got_ch.size() != 2 || got_ch[0] != 3 || got_ch[1] != 0)
            $display("FAIL wrap_order: %p, required '{3,0}", got_ch);
        else n_pass++;
        got_ch.delete(); got_bank.delete();
        run_round(4'b1111, 4'($urandom), 0, 1'b0);
        n_chk++;
        if (got_ch.size() != 4 || got_ch[0] != 1)
            $display("FAIL wrap_rr: first grant ch%0d, required ch1", got_ch.size() > 0 ? got_ch[0] : -1);
        else n_pass++;
    endtask

    task automatic test_overflow();
        got_ch.delete(); got_bank.delete();
        run_round(4'b0100, 4'b0000, 1, 1'b1);
        n_chk++;
        if (overflow[2] !== 1'b1 || got_ch.size() != 2 || got_ch[1] != 2 || got_bank[0] != 1'b0 || got_bank[1] != 1'b1)
            $display("FAIL ovf_regrant: ovf=%b grants=%p banks=%p, required ovf[2]=1 '{2,2} '{0,1}",
                     overflow, got_ch, got_bank);
        else n_pass++;
    endtask

    task automatic test_release_edge();
        got_ch.delete(); got_bank.delete();
        run_round(4'b0001, 4'b0000, 2, 1'b1);
        n_chk++;
        if (overflow[0] !== 1'b0 || got_ch.size() != 2 || got_ch[1] != 0 || got_bank[1] != 1'b1)
            $display("FAIL release_edge: ovf=%b grants=%p banks=%p, required ovf[0]=0 '{0,0} bank1",
                     overflow, got_ch, got_bank);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++)
            run_round(4'($urandom_range(1, 15)), 4'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    endtask

    task automatic test_stall();
        int n = 0;
        int s0;
        do_reset();
        s0 = n_starts;
`ifdef UDP_ARB_TIMEOUT_EN
        begin
            int ch;
            bit bk;
            @(negedge clk); req = 4'b0011; req_bank = 4'b0010;
            @(negedge clk); req = '0;
            while (tx_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            n_chk++;
            if (tx_ch !== 2'd0) $display("FAIL to_first: ch=%0d, required 0", tx_ch);
            else n_pass++;
            n = 0;
            while (timeout_err !== 1'b1 && n < TO + 20) begin @(negedge clk); n++; end
            n_chk++;
            if (timeout_err !== 1'b1 || n < TO - 1 || n > TO + 3)
                $display("FAIL to_timing: timeout_err=%b after %0d cycles, required 1 near %0d", timeout_err, n, TO);
            else n_pass++;
            serve(1, 3, 0, 1'b0, ch, bk);
            n_chk++;
            if (ch !== 1 || bk !== 1'b1 || timeout_err !== 1'b1)
                $display("FAIL to_next: ch%0d bank%0d to=%b, required ch1 bank1 to=1", ch, bk, timeout_err);
            else n_pass++;
        end
`else
        @(negedge clk); req = 4'b0001;
        @(negedge clk); req = '0;
        repeat (100) @(negedge clk);
        req = 4'b0010;
        @(negedge clk); req = '0;
        repeat (200) @(negedge clk);
        n_chk++;
        if (ch_busy !== 4'b0011 || timeout_err !== 1'b0 || n_starts - s0 !== 1)
            $display("FAIL stall: ch_busy=%b to=%b starts=%0d, required 0011 0 1", ch_busy, timeout_err, n_starts - s0);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int ch, n = 0;
        int s0;
        bit bk;
        do_reset();
        @(negedge clk); req = 4'b0010; req_bank = 4'b0010;
        @(negedge clk); req = '0;
        while (tx_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        req = 4'b0110;
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);
        #2 nRST = 1'b0;
        #1;
        n_chk++;
        if (tx_start !== 1'b0 || tx_ch !== '0 || tx_bank !== 1'b0 || ch_busy !== '0 || overflow !== '0 || timeout_err !== 1'b0)
            $display("FAIL reset_mid: start=%b ch=%0d bank=%b busy=%b ovf=%b to=%b, required all 0",
                     tx_start, tx_ch, tx_bank, ch_busy, overflow, timeout_err);
        else n_pass++;
        @(negedge clk);
        nRST = 1'b1; tx_busy = 1'b0;
        s0 = n_starts;
        repeat (20) @(negedge clk);
        n_chk++;
        if (n_starts !== s0 || ch_busy !== '0)
            $display("FAIL reset_stale: starts=%0d ch_busy=%b, required 0 and 0000", n_starts - s0, ch_busy);
        else n_pass++;
        @(negedge clk); req = 4'b1000; req_bank = 4'b0000;
        @(negedge clk); req = '0;
        serve(0, 3, 0, 1'b0, ch, bk);
        n_chk++;
        if (ch !== 3 || bk !== 1'b0) $display("FAIL reset_after: ch%0d bank%0d, required ch3 bank0", ch, bk);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_wrap();
        test_overflow();
        test_release_edge();
        test_random();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
